// File: rtl/aes_seq_ctrl.sv
// -----------------------------------------------------------------------------
// aes_seq_ctrl
//   Sequencer that sits between the CPU register-file writeback/decode stage and
//   a free-running AES-128 core. Software loads four plaintext words and four key
//   words, then pulses START. The block holds the operands stable on AES_PT /
//   AES_KEY for LATENCY cycles, captures AES_CIPHER, and exposes the captured
//   cipher one 32-bit word at a time on a registered read port.
//
//   Word order is big-endian: word 0 = bits [127:96], word 3 = bits [31:0].
//
// Ports
//   RST         in   1    asynchronous reset, active-low
//   CLK_DC      in   1    block clock (decode-stage clock)
//   WR_EN       in   1    operand write strobe
//   WR_SEL      in   3    0-3: plaintext word 0-3, 4-7: key word 0-3
//   WR_DATA     in   32   operand word
//   START       in   1    launch request (single-cycle pulse)
//   CLR         in   1    synchronous abort/clear to IDLE
//   RD_SEL      in   2    cipher word select
//   RD_DATA     out  32   selected cipher word, registered
//   BUSY        out  1    high while the core is computing
//   DONE        out  1    high while a captured cipher is valid
//   ERR         out  1    one-cycle pulse: START rejected (operands incomplete)
//   AES_PT      out  128  plaintext to core
//   AES_KEY     out  128  key to core
//   AES_CIPHER  in   128  cipher from core
// -----------------------------------------------------------------------------
module aes_seq_ctrl #(
    parameter int LATENCY = 11,   // cycles from operand launch to valid cipher (1..15)
    parameter int CNT_W   = 4     // latency counter width, must hold LATENCY
) (
    input  logic         RST,
    input  logic         CLK_DC,
    input  logic         WR_EN,
    input  logic [2:0]   WR_SEL,
    input  logic [31:0]  WR_DATA,
    input  logic         START,
    input  logic         CLR,
    input  logic [1:0]   RD_SEL,
    output logic [31:0]  RD_DATA,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR,
    output logic [127:0] AES_PT,
    output logic [127:0] AES_KEY,
    input  logic [127:0] AES_CIPHER
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       load_mask;
    logic [127:0]     pt_reg;
    logic [127:0]     key_reg;
    logic [127:0]     cipher_reg;
    logic [31:0]      rd_data_reg;
    logic             err_reg;

    // Operands may only change while the core is not consuming them.
    logic       accepting;
    logic       wr_ok;
    logic       start_ok;
    logic       start_bad;
    logic       capture;
    logic [6:0] wr_lsb;
    logic [6:0] rd_lsb;

    assign accepting = (state != ST_RUN);
    assign wr_ok     = WR_EN && accepting && !CLR;
    // The START check looks at the mask as registered, i.e. before any write
    // arriving in the same cycle has set its bit.
    assign start_ok  = START && accepting && !CLR && (load_mask == 8'hFF);
    assign start_bad = START && accepting && !CLR && (load_mask != 8'hFF);
    assign capture   = (state == ST_RUN) && (cnt == '0) && !CLR;

    // Big-endian word placement: word n sits at bit offset 32*(3-n); ~sel == 3-sel.
    assign wr_lsb = {~WR_SEL[1:0], 5'b0_0000};
    assign rd_lsb = {~RD_SEL, 5'b0_0000};

    // Sequencer state and latency counter.
    // NOTE: every flop below is written with non-blocking assignments so all
    // registers update from the same pre-edge values, independent of block order.
    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (CLR) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state <= ST_RUN;
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_RUN: begin
                    if (cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Load mask: one bit per operand word. A launch consumes the operand set,
    // so the mask restarts empty on every entry into RUN.
    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            load_mask <= 8'h00;
        end else if (CLR || start_ok) begin
            load_mask <= 8'h00;
        end else if (wr_ok) begin
            load_mask[WR_SEL] <= 1'b1;
        end
    end

    // Operand registers drive the core directly, so they stay stable during RUN.
    // CLR leaves them untouched; only a write replaces a word.
    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            pt_reg  <= '0;
            key_reg <= '0;
        end else if (wr_ok) begin
            if (WR_SEL[2]) begin
                key_reg[wr_lsb +: 32] <= WR_DATA;
            end else begin
                pt_reg[wr_lsb +: 32] <= WR_DATA;
            end
        end
    end

    // Cipher capture on the final RUN cycle; held through DONE, CLR and relaunch
    // until the next completed run overwrites it.
    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            cipher_reg <= '0;
        end else if (capture) begin
            cipher_reg <= AES_CIPHER;
        end
    end

    // Registered read port and error pulse.
    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            rd_data_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            rd_data_reg <= cipher_reg[rd_lsb +: 32];
            err_reg     <= start_bad;
        end
    end

    assign AES_PT  = pt_reg;
    assign AES_KEY = key_reg;
    assign RD_DATA = rd_data_reg;
    assign ERR     = err_reg;
    assign BUSY    = (state == ST_RUN);
    assign DONE    = (state == ST_DONE);

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_seq_ctrl
//   Directed bench for aes_seq_ctrl. The AES core is modelled by driving
//   AES_CIPHER with junk on every RUN cycle except the last one, where the
//   expected cipher is presented; any early or late capture therefore shows up
//   on the read port.
// -----------------------------------------------------------------------------
module tb_aes_seq_ctrl;

    localparam logic [127:0] PT_VEC   = 128'h01020304_05060708_090a0b0c_0d0e0f10;
    localparam logic [127:0] KEY_VEC  = 128'h02030405_06070809_0a0b0c0d_0e0f1011;
    localparam logic [127:0] GOOD_CT  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
    localparam logic [127:0] JUNK_CT  = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

    logic         rst;
    logic         clk_dc;
    logic         wr_en;
    logic [2:0]   wr_sel;
    logic [31:0]  wr_data;
    logic         start;
    logic         clr;
    logic [1:0]   rd_sel;
    logic [31:0]  rd_data;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] aes_pt;
    logic [127:0] aes_key;
    logic [127:0] aes_cipher;

    int errors = 0;
    int checks = 0;

    aes_seq_ctrl #(
        .LATENCY (11),
        .CNT_W   (4)
    ) dut (
        .RST        (rst),
        .CLK_DC     (clk_dc),
        .WR_EN      (wr_en),
        .WR_SEL     (wr_sel),
        .WR_DATA    (wr_data),
        .START      (start),
        .CLR        (clr),
        .RD_SEL     (rd_sel),
        .RD_DATA    (rd_data),
        .BUSY       (busy),
        .DONE       (done),
        .ERR        (err),
        .AES_PT     (aes_pt),
        .AES_KEY    (aes_key),
        .AES_CIPHER (aes_cipher)
    );

    initial clk_dc = 1'b0;
    always #5 clk_dc = ~clk_dc;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk_dc);
        #1;
    endtask

    task automatic write_word(input logic [2:0] sel, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_all();
        for (int w = 0; w < 4; w++) write_word(3'(w), PT_VEC[127 - 32*w -: 32]);
        for (int w = 0; w < 4; w++) write_word(3'(4 + w), KEY_VEC[127 - 32*w -: 32]);
    endtask

    // Launch and step through all 11 RUN cycles. The core only presents the
    // real cipher in the last RUN cycle. With inject set, the first RUN cycle
    // also carries an operand write and a redundant START, both to be ignored.
    task automatic launch_and_run(input string tag, input logic inject);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            aes_cipher = (i == 10) ? GOOD_CT : (JUNK_CT ^ 128'(i));
            check({tag, " busy in run"}, 128'(busy), 128'(1'b1));
            check({tag, " done in run"}, 128'(done), 128'(1'b0));
            if (inject && i == 0) begin
                wr_en   = 1'b1;
                wr_sel  = 3'd2;
                wr_data = 32'hDEADBEEF;
                start   = 1'b1;
            end
            tick();
            if (inject && i == 0) begin
                wr_en = 1'b0;
                start = 1'b0;
                check({tag, " pt word2 held"}, 128'(aes_pt[63:32]), 128'(32'h090a0b0c));
                check({tag, " no err on run start"}, 128'(err), 128'(1'b0));
            end
        end
        aes_cipher = JUNK_CT;
        check({tag, " busy after run"}, 128'(busy), 128'(1'b0));
        check({tag, " done after run"}, 128'(done), 128'(1'b1));
    endtask

    task automatic read_word(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        rd_sel = sel;
        tick();
        check(tag, 128'(rd_data), 128'(exp));
    endtask

    initial begin
        rst        = 1'b0;
        wr_en      = 1'b0;
        wr_sel     = 3'd0;
        wr_data    = 32'h0;
        start      = 1'b0;
        clr        = 1'b0;
        rd_sel     = 2'd0;
        aes_cipher = JUNK_CT;

        // Reset values.
        #1;
        check("reset pt",   aes_pt,            128'h0);
        check("reset key",  aes_key,           128'h0);
        check("reset rd",   128'(rd_data),     128'h0);
        check("reset busy", 128'(busy),        128'h0);
        check("reset done", 128'(done),        128'h0);
        check("reset err",  128'(err),         128'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1: full load, 11-cycle run, read back the four words in order.
        load_all();
        check("t1 pt loaded",  aes_pt,  PT_VEC);
        check("t1 key loaded", aes_key, KEY_VEC);
        launch_and_run("t1", 1'b0);
        read_word("t1 rd word0", 2'd0, GOOD_CT[127:96]);
        read_word("t1 rd word1", 2'd1, GOOD_CT[95:64]);
        read_word("t1 rd word2", 2'd2, GOOD_CT[63:32]);
        read_word("t1 rd word3", 2'd3, GOOD_CT[31:0]);
        check("t1 done holds", 128'(done), 128'(1'b1));

        // 3: relaunch from DONE with a write and START injected during RUN.
        load_all();
        launch_and_run("t3", 1'b1);
        check("t3 pt intact", aes_pt, PT_VEC);
        read_word("t3 rd word0", 2'd0, GOOD_CT[127:96]);
        read_word("t3 rd word3", 2'd3, GOOD_CT[31:0]);

        // 2: clear to IDLE, load only the plaintext, START is rejected.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t2 clr busy", 128'(busy), 128'(1'b0));
        check("t2 clr done", 128'(done), 128'(1'b0));
        for (int w = 0; w < 4; w++) write_word(3'(w), PT_VEC[127 - 32*w -: 32]);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2 err pulse",  128'(err),  128'(1'b1));
        check("t2 busy low",   128'(busy), 128'(1'b0));
        check("t2 done low",   128'(done), 128'(1'b0));
        tick();
        check("t2 err one cycle", 128'(err), 128'(1'b0));
        check("t2 still idle",    128'(busy), 128'(1'b0));

        // Same-cycle write and START: write lands, START judged on old mask.
        write_word(3'd4, 32'h02030405);
        write_word(3'd5, 32'h06070809);
        write_word(3'd6, 32'h0a0b0c0d);
        wr_en   = 1'b1;
        wr_sel  = 3'd7;
        wr_data = 32'h77777777;
        start   = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        check("wr+start err",     128'(err),           128'(1'b1));
        check("wr+start no run",  128'(busy),          128'(1'b0));
        check("wr+start written", 128'(aes_key[31:0]), 128'(32'h77777777));

        // 4: now complete, launch and abort with CLR in RUN cycle 5.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4 run entered", 128'(busy), 128'(1'b1));
        for (int i = 0; i < 4; i++) tick();
        check("t4 still run c5", 128'(busy), 128'(1'b1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4 clr busy", 128'(busy), 128'(1'b0));
        check("t4 clr done", 128'(done), 128'(1'b0));
        check("t4 operands kept", aes_key, {KEY_VEC[127:32], 32'h77777777});
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4 start after clr err", 128'(err),  128'(1'b1));
        check("t4 start after clr idle", 128'(busy), 128'(1'b0));

        // 5: asynchronous reset in RUN cycle 3.
        load_all();
        rd_sel = 2'd0;
        aes_cipher = GOOD_CT;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t5 run c3 busy", 128'(busy), 128'(1'b1));
        check("t5 rd before rst", 128'(rd_data), 128'(GOOD_CT[127:96]));
        #2;
        rst = 1'b0;
        #1;
        check("t5 rst pt",   aes_pt,        128'h0);
        check("t5 rst key",  aes_key,       128'h0);
        check("t5 rst rd",   128'(rd_data), 128'h0);
        check("t5 rst busy", 128'(busy),    128'h0);
        check("t5 rst done", 128'(done),    128'h0);
        check("t5 rst err",  128'(err),     128'h0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("t5 no done after rst", 128'(done), 128'(1'b0));
        check("t5 no busy after rst", 128'(busy), 128'(1'b0));
        read_word("t5 no capture", 2'd0, 32'h0);
        aes_cipher = JUNK_CT;

        // 6: from DONE, rewrite everything; final write with START and CLR.
        load_all();
        launch_and_run("t6 setup", 1'b0);
        for (int w = 0; w < 4; w++) write_word(3'(w), 32'hA0A0A0A0 + 32'(w));
        for (int w = 0; w < 3; w++) write_word(3'(4 + w), 32'hB0B0B0B0 + 32'(w));
        wr_en   = 1'b1;
        wr_sel  = 3'd7;
        wr_data = 32'h55555555;
        start   = 1'b1;
        clr     = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        check("t6 busy",        128'(busy),            128'(1'b0));
        check("t6 done",        128'(done),            128'(1'b0));
        check("t6 err",         128'(err),             128'(1'b0));
        check("t6 pt rewritten", 128'(aes_pt[127:96]), 128'(32'hA0A0A0A0));
        check("t6 clr drops wr", 128'(aes_key[31:0]),  128'(KEY_VEC[31:0]));
        read_word("t6 cipher kept", 2'd3, GOOD_CT[31:0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6 mask cleared err", 128'(err),  128'(1'b1));
        check("t6 mask cleared idle", 128'(busy), 128'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
